// File: rtl/lfsr_arb_pkg.sv
// Shared definitions for the LFSR random-source arbiter: LFSR width/taps,
// FSM state type and the LFSR step function.
package lfsr_arb_pkg;

  localparam int unsigned LFSR_W = 10;
  localparam int unsigned TAP_HI = 9;
  localparam int unsigned TAP_LO = 6;

  typedef enum logic [0:0] {
    StWarmup,
    StServe
  } state_e;

  // Fibonacci step for x^10+x^7+1; an all-zero register is forced back to 1
  // so a corrupted LFSR cannot lock up.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    if (cur == '0) begin
      return LFSR_W'(1);
    end
    return {cur[LFSR_W-2:0], cur[TAP_HI] ^ cur[TAP_LO]};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible requester at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_valid
);

  // Scan NUM_REQ positions starting at rr_ptr; keep the first hit.
  always_comb begin
    int unsigned       idx;
    logic [PTR_W-1:0]  idx_t;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx   = (32'(rr_ptr) + i) % NUM_REQ;
      idx_t = PTR_W'(idx);
      if (!any_valid && eligible[idx_t]) begin
        any_valid = 1'b1;
        winner    = idx_t;
      end
    end
  end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter sharing one 10-bit LFSR between NUM_REQ requesters.
// Every grant delivers the current LFSR word and steps the LFSR once.
// Optional grant counter output enabled by defining LFSR_ARB_GRANT_CNT_EN.
module lfsr_rng_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int unsigned       NUM_REQ = 4,
  parameter logic [LFSR_W-1:0] SEED    = 10'h001,
  parameter int unsigned       WARMUP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_valid,
  input  logic [LFSR_W-1:0]  seed_data,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [LFSR_W-1:0]  rnd_data,
  output logic               busy
`ifdef LFSR_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]        grant_cnt
`endif
);

  localparam int unsigned       PTR_W      = $clog2(NUM_REQ);
  localparam logic [LFSR_W-1:0] SEED_INIT  = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam state_e            STATE_INIT = (WARMUP == 0) ? StServe : StWarmup;
  localparam logic [7:0]        WARM_LAST  = 8'((WARMUP == 0) ? 0 : WARMUP - 1);

  state_e              state;
  logic [LFSR_W-1:0]   lfsr;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    winner;
  logic [PTR_W-1:0]    ptr_next;
  logic [7:0]          warm_cnt;
  logic [NUM_REQ-1:0]  eligible;
  logic                any_valid;

  // Mask last cycle's winner so a held request cannot take consecutive grants.
  always_comb begin
    eligible = req & ~gnt;
    ptr_next = (32'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign busy = (state == StWarmup);

  // FSM, LFSR and registered grant outputs; a reseed overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= STATE_INIT;
      lfsr      <= SEED_INIT;
      rr_ptr    <= '0;
      warm_cnt  <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      if (seed_valid) begin
        lfsr     <= (seed_data == '0) ? LFSR_W'(1) : seed_data;
        state    <= StServe;
        warm_cnt <= '0;
      end else begin
        unique case (state)
          StWarmup: begin
            lfsr     <= lfsr_next(lfsr);
            warm_cnt <= warm_cnt + 8'd1;
            if (warm_cnt == WARM_LAST) begin
              state <= StServe;
            end
          end
          StServe: begin
            if (any_valid) begin
              gnt       <= NUM_REQ'(1) << winner;
              rnd_valid <= 1'b1;
              rnd_data  <= lfsr;
              lfsr      <= lfsr_next(lfsr);
              rr_ptr    <= ptr_next;
            end
          end
          default: state <= StWarmup;
        endcase
      end
    end
  end

`ifdef LFSR_ARB_GRANT_CNT_EN
  // Saturating grant counter; advances on the edge that raises rnd_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
    end else if (seed_valid) begin
      grant_cnt <= '0;
    end else if (state == StServe && any_valid && grant_cnt != 16'hFFFF) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
Shares one 10-bit maximal-length LFSR random source between NUM_REQ requesters using round-robin arbitration.
- Each grant returns one LFSR word and advances the LFSR one step, so no two requesters ever receive the same word.
- Runs a post-reset warm-up so the first delivered word is not the seed.
- Accepts a runtime reseed from a configuration master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SEED, 10'h001, LFSR value after reset; 0 is illegal and is replaced by 10'h001
WARMUP, 8, LFSR steps taken after reset before the first grant (0..255; 0 = start directly in SERVE)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request, one bit per requester
seed_valid  in  1  one-cycle strobe; load seed_data
seed_data  in  10  new LFSR value
gnt  out  NUM_REQ  registered one-hot grant pulse
rnd_valid  out  1  high in the same cycle as any gnt bit
rnd_data  out  10  random word for the granted requester, valid with rnd_valid
busy  out  1  high while in WARMUP

Behaviour:
- Reset (rst low, async):
  - gnt=0, rnd_valid=0, rnd_data=0.
  - lfsr=SEED (10'h001 if SEED==0), rr_ptr=0, warm_cnt=0.
  - State is WARMUP, with busy=1 (SERVE, busy=0 if WARMUP==0).
- LFSR step: Fibonacci, polynomial x^10+x^7+1, next = {lfsr[8:0], lfsr[9]^lfsr[6]}, period 1023. Sequence from 001: 002,004,008,010,020,040,081,102,204,009...
- WARMUP:
  - lfsr steps every cycle and warm_cnt increments.
  - When warm_cnt==WARMUP-1, next state is SERVE. busy drops on the cycle SERVE is entered.
  - req is ignored and no grants are issued.
- SERVE:
  - Each cycle: eligible = req & ~gnt. A requester granted last cycle is masked for one cycle, so a level req yields at most one grant every 2 cycles per requester.
  - If eligible is non-zero, winner = first set bit searching upward from rr_ptr with wrap-around.
  - Registered outputs on the next edge: gnt=onehot(winner), rnd_valid=1, rnd_data=lfsr (pre-step value), lfsr steps, rr_ptr=(winner+1) mod NUM_REQ.
  - If eligible==0: gnt=0, rnd_valid=0, rnd_data holds its last value, lfsr holds.
- Latency: req high at edge t gives gnt/rnd_data visible after edge t+1 (1 cycle). With distinct requesters, grants can issue back-to-back every cycle.
- Reseed:
  - seed_valid in any state: lfsr = (seed_data==0 ? 10'h001 : seed_data). Next state is SERVE, warm_cnt is cleared, busy drops.
  - That cycle issues no grant (gnt=0, rnd_valid=0) and rr_ptr holds. Seed wins over any simultaneous request; requests are served from the following cycle.
- Reset asserted mid-grant clears gnt immediately (async) and restarts WARMUP.
- The LFSR never holds 0 under legal operation. If lfsr==0 is ever detected, the next step forces 10'h001 (lock-up recovery).

Optional Feature:
- Macro: LFSR_ARB_GRANT_CNT_EN.
- Defined: adds output grant_cnt [15:0].
  - Increments on every rnd_valid and saturates at 16'hFFFF.
  - Reset to 0; cleared by seed_valid.
- Undefined: port absent and no counter logic.
- Core behaviour is identical either way.

Decomposition:
- Package lfsr_arb_pkg:
  - LFSR_W=10 and tap positions 9 and 6.
  - state enum {WARMUP, SERVE}.
  - function lfsr_next (including the zero-recovery rule).
- Sub-module rr_pick (combinational): inputs eligible and rr_ptr; outputs winner index and any_valid.
- The top level holds the FSM, LFSR register, counters and output registers.

Test Plan:
- Reset with default params, req=0 for 12 cycles: busy high for exactly 8 cycles after reset release, then low; gnt and rnd_valid stay 0 throughout.
- After warm-up, req=4'b0001 held: grants occur every other cycle; rnd_data sequence 102, 204, 009, 012.
- req=4'b1111 held from SERVE entry: gnt order 0001, 0010, 0100, 1000, 0001 on consecutive cycles; rnd_data follows the LFSR sequence with no repeats.
- seed_valid=1, seed_data=0 in the same cycle as req=4'b0010: no grant that cycle; next cycle gnt=0010 with rnd_data=001, then 002 on its following grant.
- seed_valid during WARMUP (cycle 3) with seed 10'h155: busy drops the next cycle; first grant delivers 155.
- Reset asserted between two grants with req=4'b1111 held: gnt clears asynchronously; after release, 8 busy cycles, then rr_ptr restarts at requester 0 and the first rnd_data is 102. With LFSR_ARB_GRANT_CNT_EN defined, grant_cnt reads 0 after reset and counts 1 per grant.
